// File: rtl/reg_file.sv
// Two-read, one-write register file with a hardwired zero register.
// Synchronous clear; reads are purely combinational with no write bypass.
module reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic [DATA_WIDTH-1:0] rd_data_b
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  wr_ok;

    assign wr_ok = wr_en && (wr_addr != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Address 0 is forced to zero at the read mux so it never depends on storage.
    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        if (rd_addr_a != '0) begin
            rd_data_a = regs[rd_addr_a];
        end
        if (rd_addr_b != '0) begin
            rd_data_b = regs[rd_addr_b];
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: array model checked every cycle plus literal
// expectations for the reset, zero-register, read-during-write and sweep cases.
module tb_reg_file;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic [DW-1:0] rd_data_a;
    logic [DW-1:0] rd_data_b;

    int compared   = 0;
    int mismatched = 0;

    logic [DW-1:0] model [32];
    bit            armed = 1'b0;

    reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b)
    );

    always #5 clk = ~clk;

    // Model: reset clears everything, otherwise a non-zero-address write lands.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) model[i] <= '0;
            armed <= 1'b1;
        end else if (wr_en && wr_addr != 0) begin
            model[wr_addr] <= wr_data;
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("model_port_a", rd_data_a, model[rd_addr_a]);
            chk("model_port_b", rd_data_b, model[rd_addr_b]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        step();
        chk("reset_a", rd_data_a, 32'h0);
        reset = 1'b0;

        // Reset clears an earlier write, and reads stay zero while reset is held
        wr(5'd5, 32'hDEADBEEF);
        rd_addr_a = 5'd5;
        @(negedge clk);
        chk("r5_written", rd_data_a, 32'hDEADBEEF);
        reset = 1'b1;
        step();
        @(negedge clk);
        chk("r5_during_reset", rd_data_a, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("r5_after_reset", rd_data_a, 32'h0);

        wr(5'd7, 32'h12345678);
        wr(5'd31, 32'hCAFEF00D);
        rd_addr_a = 5'd7;
        rd_addr_b = 5'd31;
        @(negedge clk);
        chk("r7_port_a", rd_data_a, 32'h12345678);
        chk("r31_port_b", rd_data_b, 32'hCAFEF00D);
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = AW'(i);
            rd_addr_b = AW'(i);
            #2;
            if (i != 7 && i != 31) chk("others_zero", rd_data_a, 32'h0);
        end

        wr(5'd0, 32'hFFFFFFFF);
        rd_addr_a = 5'd0;
        rd_addr_b = 5'd0;
        @(negedge clk);
        chk("r0_port_a", rd_data_a, 32'h0);
        chk("r0_port_b", rd_data_b, 32'h0);
        rd_addr_a = 5'd1;
        rd_addr_b = 5'd7;
        @(negedge clk);
        chk("r1_after_r0_write", rd_data_a, 32'h0);
        chk("r7_after_r0_write", rd_data_b, 32'h12345678);

        // Read-during-write returns the old value until the edge
        wr(5'd3, 32'h11111111);
        wr_en     = 1'b1;
        wr_addr   = 5'd3;
        wr_data   = 32'h22222222;
        rd_addr_a = 5'd3;
        rd_addr_b = 5'd3;
        @(negedge clk);
        chk("rdw_old_a", rd_data_a, 32'h11111111);
        chk("rdw_old_b", rd_data_b, 32'h11111111);
        step();
        wr_en = 1'b0;
        chk("rdw_new_a", rd_data_a, 32'h22222222);
        @(negedge clk);
        chk("rdw_new_b", rd_data_b, 32'h22222222);

        reset   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 5'd9;
        wr_data = 32'hAAAAAAAA;
        step();
        reset = 1'b0;
        wr_en = 1'b0;
        rd_addr_a = 5'd9;
        rd_addr_b = 5'd3;
        @(negedge clk);
        chk("reset_priority_r9", rd_data_a, 32'h0);
        chk("reset_cleared_r3", rd_data_b, 32'h0);

        // Writes resume on the first edge after reset drops
        wr(5'd4, 32'h0BADF00D);
        rd_addr_a = 5'd4;
        @(negedge clk);
        chk("resume_r4", rd_data_a, 32'h0BADF00D);

        for (int i = 1; i < 32; i++) wr(AW'(i), DW'(i) * 32'h01010101);
        for (int i = 0; i < 20; i++) begin
            wr_en   = 1'b0;
            wr_addr = AW'($urandom_range(0, 31));
            wr_data = $urandom;
            step();
        end
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = AW'(i);
            rd_addr_b = AW'(31 - i);
            @(negedge clk);
            chk("sweep_a", rd_data_a, DW'(i) * 32'h01010101);
            chk("sweep_b", rd_data_b, DW'(31 - i) * 32'h01010101);
        end
        rd_addr_a = 5'd17;
        rd_addr_b = 5'd17;
        @(negedge clk);
        chk("r17_literal", rd_data_a, 32'h11111111);
        chk("same_addr", rd_data_b, 32'h11111111);
        rd_addr_a = 5'd31;
        @(negedge clk);
        chk("r31_literal", rd_data_a, 32'h1F1F1F1F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter: DATA_WIDTH, 32, bit width of each register and of every data port.
REQ-002 Parameter: ADDR_WIDTH, 5, address width; register count = 2**ADDR_WIDTH (32 at default).
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 wr_en  input  1  write enable, sampled at rising clk.
REQ-006 wr_addr  input  ADDR_WIDTH  destination register index.
REQ-007 wr_data  input  DATA_WIDTH  data to write.
REQ-008 rd_addr_a  input  ADDR_WIDTH  read port A index.
REQ-009 rd_addr_b  input  ADDR_WIDTH  read port B index.
REQ-010 rd_data_a  output  DATA_WIDTH  contents of register rd_addr_a.
REQ-011 rd_data_b  output  DATA_WIDTH  contents of register rd_addr_b.

Function
REQ-012 Storage SHALL be 2**ADDR_WIDTH registers, each DATA_WIDTH flip-flops, updated only on the rising edge of clk.
REQ-013 Write: at the rising edge with reset=0, wr_en=1 and wr_addr!=0, the register at wr_addr SHALL take wr_data; all other registers SHALL hold.
REQ-014 wr_en=0 SHALL leave every register unchanged, whatever wr_addr and wr_data are.
REQ-015 Register 0 SHALL always read 0; a write to address 0 SHALL be discarded with no side effect on other registers.
REQ-016 Reads SHALL be combinational, with zero-cycle latency from rd_addr_x to rd_data_x and no clock involved.
REQ-017 Both read ports SHALL be independent; equal rd_addr_a and rd_addr_b SHALL return identical data.
REQ-018 Read-during-write: in the cycle a write to address N is pending, a read of N SHALL return the old value; the new value SHALL appear only after the rising edge (no bypass).
REQ-019 A write to N at edge k SHALL be visible on any read port addressing N from edge k onward, until overwritten.
REQ-020 Data SHALL be stored and returned bit-exact; no sign extension, truncation or arithmetic.
REQ-021 Outputs SHALL never be X or Z after the first reset edge, for any known address.

Reset
REQ-022 At the rising edge with reset=1, every register SHALL become 0.
REQ-023 Reset SHALL take priority over a write at the same edge; the write SHALL be discarded.
REQ-024 While reset=1, rd_data_a and rd_data_b SHALL read 0 for every address from the first reset edge onward.
REQ-025 Reset asserted part-way through a write sequence SHALL clear all earlier writes; writes SHALL resume at the first edge with reset=0.
REQ-026 Register contents before the first reset edge are undefined and SHALL NOT be relied on.

Verification
REQ-027 Reset clear: write 0xDEADBEEF to r5, assert reset for 1 edge, then rd_addr_a=5 -> rd_data_a=0x00000000.
REQ-028 Write/read: write 0x12345678 to r7 and 0xCAFEF00D to r31; rd_addr_a=7, rd_addr_b=31 -> 0x12345678 and 0xCAFEF00D; all other registers 0.
REQ-029 Zero register: wr_en=1, wr_addr=0, wr_data=0xFFFFFFFF, then read r0 on both ports -> 0x00000000; r1-r31 unchanged.
REQ-030 Read-during-write: r3=0x11111111, then a write of 0x22222222 to r3 -> before the edge rd_data_a=0x11111111, after the edge 0x22222222.
REQ-031 Reset priority: reset=1 with wr_en=1, wr_addr=9, wr_data=0xAAAAAAAA at the same edge -> r9 reads 0x00000000.
REQ-032 Exhaustive: write value (i*0x01010101) to each ri for i=1..31, then sweep both read ports over all 32 addresses -> each reads its written value, r0 reads 0; wr_en=0 cycles with random wr_addr/wr_data change nothing.
